// File: rtl/rand_word_packer.sv
// Packs rising-edge-captured PRNG bytes little-endian into words and buffers them in an FWFT FIFO.
// Optional feature: define RAND_PACK_STATS_EN to add the saturating word_cnt output.
module rand_word_packer #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      flush,
  input  logic [7:0]                prng_dout,
  input  logic                      prng_done,
  output logic                      prng_ena,
  output logic [8*WORD_BYTES-1:0]   dout,
  output logic                      valid,
  input  logic                      ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf
`ifdef RAND_PACK_STATS_EN
  ,
  output logic [15:0]               word_cnt
`endif
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic                    done_q, done_d;
  logic [BW-1:0]           bidx_q, bidx_d;
  logic [W-1:0]            word_q, word_d, word_ins;
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    capture, last, full, pop, push_req, do_push;

  always_comb begin
    capture  = prng_done && !done_q;
    last     = (bidx_q == LAST_IDX);
    full     = (cnt_q == FULL_CNT);
    pop      = (cnt_q != '0) && ready;
    push_req = capture && last;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push_req && (!full || pop);

    word_ins = word_q;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (bidx_q == BW'(k)) word_ins[8*k +: 8] = prng_dout;
    end

    done_d = prng_done;
    bidx_d = bidx_q;
    word_d = word_q;
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    if (flush) begin
      bidx_d = '0;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (capture) begin
        word_d = word_ins;
        bidx_d = last ? '0 : bidx_q + BW'(1);
      end
      if (do_push) begin
        mem_d[wptr_q] = word_ins;
        wptr_d        = wptr_q + PW'(1);
      end
      if (push_req && !do_push) ovf_d = 1'b1;
      if (pop) rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      done_q <= 1'b0;
      bidx_q <= '0;
      word_q <= '0;
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      bidx_q <= bidx_d;
      word_q <= word_d;
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout     = mem_q[rptr_q];
  assign valid    = (cnt_q != '0);
  assign level    = cnt_q;
  assign ovf      = ovf_q;
  assign prng_ena = !flush && (cnt_q < FULL_CNT);

`ifdef RAND_PACK_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (flush)                               word_cnt_d = '0;
    else if (pop && word_cnt_q != 16'hFFFF)  word_cnt_d = word_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_rand_word_packer.sv
// Random + directed bench for rand_word_packer against a queue-based reference model.
module tb_rand_word_packer;
  localparam int WB    = 4;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   res, flush, prng_done, ready;
  logic [7:0]             prng_dout;
  logic                   prng_ena, valid, ovf;
  logic [8*WB-1:0]        dout;
  logic [$clog2(DEPTH):0] level;
`ifdef RAND_PACK_STATS_EN
  logic [15:0]            word_cnt;
`endif

  always #5 clk = ~clk;

  rand_word_packer #(.WORD_BYTES(WB), .DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .flush(flush), .prng_dout(prng_dout), .prng_done(prng_done),
    .prng_ena(prng_ena), .dout(dout), .valid(valid), .ready(ready), .level(level), .ovf(ovf)
`ifdef RAND_PACK_STATS_EN
    , .word_cnt(word_cnt)
`endif
  );

  // reference model: word queue plus list of bytes collected so far
  logic [8*WB-1:0] q[$];
  logic [7:0]      part[$];
  bit              m_prev, m_ovf;
  int              m_wc;
  int              n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    part.delete();
    m_prev = 0;
    m_ovf  = 0;
    m_wc   = 0;
  endtask

  task automatic model_step();
    bit              cap, pop;
    int              sz;
    logic [8*WB-1:0] w;
    if (res) begin
      model_reset();
      return;
    end
    cap    = prng_done && !m_prev;
    m_prev = prng_done;
    if (flush) begin
      q.delete();
      part.delete();
      m_ovf = 0;
      m_wc  = 0;
      return;
    end
    sz  = q.size();
    pop = (sz > 0) && ready;
    if (pop) begin
      void'(q.pop_front());
      if (m_wc < 65535) m_wc++;
    end
    if (cap) begin
      part.push_back(prng_dout);
      if (part.size() == WB) begin
        w = '0;
        for (int i = 0; i < WB; i++) w = w | ((8*WB)'(part[i]) << (8*i));
        part.delete();
        if (sz == DEPTH && !pop) m_ovf = 1;
        else                     q.push_back(w);
      end
    end
  endtask

  task automatic check_all();
    chk("valid", valid, q.size() != 0);
    chk("level", level, q.size());
    if (q.size() != 0) chk("dout", dout, q[0]);
    chk("prng_ena", prng_ena, !flush && (q.size() < DEPTH));
    chk("ovf", ovf, m_ovf);
`ifdef RAND_PACK_STATS_EN
    chk("word_cnt", word_cnt, m_wc);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    prng_dout = b;
    prng_done = 1'b1;
    repeat (hold) tick();
    prng_done = 1'b0;
    repeat (7) tick();
  endtask

  task automatic async_reset();
    #2;
    res = 1'b1;
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_ena", prng_ena, 1'b1);
    chk("rst_dout", dout, 0);
`ifdef RAND_PACK_STATS_EN
    chk("rst_word_cnt", word_cnt, 0);
`endif
    model_reset();
    prng_done = 1'b0;
    tick();
    tick();
    res = 1'b0;
    tick();
  endtask

  initial begin
    int  gen, hold;
    bit  viol;
    n_chk = 0; n_fail = 0;
    res = 1'b1; flush = 1'b0; prng_done = 1'b0; ready = 1'b0; prng_dout = 8'h00;
    model_reset();
    #1;
    chk("init_valid", valid, 1'b0);
    chk("init_ena", prng_ena, 1'b1);
    chk("init_dout", dout, 0);
    tick();
    res = 1'b0;
    tick();

    // four bytes -> one little-endian word, visible one cycle after 4th done
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    prng_dout = 8'h44;
    prng_done = 1'b1;
    tick();
    chk("d1_valid", valid, 1'b1);
    chk("d1_level", level, 1);
    chk("d1_word", dout, 32'h44332211);
    prng_done = 1'b0;
    repeat (7) tick();

    // a done level held 20 cycles captures once
    send_byte(8'hAA, 20);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    chk("d2_level", level, 2);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("d2_word", dout, 32'h030201AA);

    // fill to DEPTH, throttle, pop one, order preserved
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 1);
    chk("d3_full", level, DEPTH);
    chk("d3_ena_lo", prng_ena, 1'b0);
    chk("d3_head", dout, 32'h04030201);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("d3_ena_hi", prng_ena, 1'b1);
    chk("d3_next", dout, 32'h08070605);
    for (int i = 17; i <= 20; i++) send_byte(8'(i), 1);
    chk("d3_refull", level, DEPTH);

    // push while full, no pop -> dropped, sticky ovf until flush
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1);
    chk("d4_ovf", ovf, 1'b1);
    chk("d4_level", level, DEPTH);
    chk("d4_head", dout, 32'h08070605);
    repeat (5) tick();
    chk("d4_sticky", ovf, 1'b1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("d4_clr", ovf, 1'b0);

    // flush discards a partial word; capture coinciding with flush is dropped
    send_byte(8'hA1, 1);
    send_byte(8'hA2, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    prng_dout = 8'hEE; prng_done = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; prng_done = 1'b0;
    repeat (7) tick();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1);
    chk("d5_word", dout, 32'h04030201);
    chk("d5_level", level, 1);

    // handshake count, then async reset mid-word
    flush = 1'b1; tick(); flush = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), 1);
`ifdef RAND_PACK_STATS_EN
    chk("d6_word_cnt", word_cnt, 3);
`endif
    ready = 1'b0;
    send_byte(8'h5A, 1);
    send_byte(8'h6B, 1);
    async_reset();

    // randomized PRNG stub, occasionally ignoring ena to provoke overflow
    gen = 0; hold = 0; viol = 0;
    for (int c = 0; c < 4000; c++) begin
      viol  = (c % 700) >= 550;
      ready = viol ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      flush = ($urandom % 250 == 0);
      if (prng_done) begin
        if (hold > 0) hold--;
        else          prng_done = 1'b0;
      end else if (prng_ena || viol) begin
        gen++;
        if (gen >= (viol ? 3 : 8)) begin
          gen       = 0;
          prng_done = 1'b1;
          prng_dout = 8'($urandom);
          hold      = $urandom_range(0, 3);
        end
      end
      tick();
      if (c == 2100) begin
        flush = 1'b0;
        async_reset();
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/rand_word_packer.md
# rand_word_packer

- Sits directly downstream of the team's 8-bit LFSR PRNG. Consumes its `dout`/`done` byte stream and throttles it through the PRNG's `ena` input.
- Packs `WORD_BYTES` consecutive bytes into one word, little-endian, and buffers the words in a first-word-fall-through (FWFT) FIFO.
- Delivers words to consumers with a valid/ready handshake, so random words are available without waiting on the 8-cycle-per-byte generation rate.

## Interface
- `WORD_BYTES`, default 4: bytes per output word; legal values 1..4.
- `DEPTH`, default 4: FIFO depth in words; must be a power of 2, ≥2.
- `clk` in 1: single clock, rising edge.
- `res` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous clear of the packer and the FIFO.
- `prng_dout` in 8: byte from the PRNG.
- `prng_done` in 1: PRNG byte-complete flag. It is a level and may stay high while the PRNG is stalled.
- `prng_ena` out 1: enable to the PRNG.
- `dout` out 8*WORD_BYTES: head word of the FIFO.
- `valid` out 1: head word is valid.
- `ready` in 1: consumer accepts the head word.
- `level` out $clog2(DEPTH)+1: number of words in the FIFO.
- `ovf` out 1: sticky flag, set when a word was dropped.

## Operation
- Byte capture:
  - `done_q` registers `prng_done`.
  - A byte is captured only on a rising edge of `prng_done` (`prng_done && !done_q`). A level that stays high never captures twice.
- Packer:
  - `bidx` counts captured bytes, 0..WORD_BYTES-1.
  - Byte k is stored into `word[8k+7:8k]`.
  - When `bidx == WORD_BYTES-1`, the word completes: it is pushed and `bidx` wraps to 0.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(DEPTH) and a separate count.
  - `dout` shows the head entry combinationally from storage (FWFT). `valid = (level != 0)`.
  - Pop when `valid && ready`.
- Push/pop rules:
  - Push when full with no pop in the same cycle: the word is dropped, `ovf` is set, and the pointers are unchanged.
  - Push and pop in the same cycle while full: both succeed and `level` is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect. A pop requires `valid` already high.
- Throttle:
  - `prng_ena = !flush && (level < DEPTH)`, combinational.
  - The PRNG needs at least 8 enabled cycles per byte, so an overflow is unreachable with a compliant PRNG. `ovf` exists to catch protocol violations.
- `flush`:
  - Clears `bidx`, `level`, both pointers and `ovf`.
  - Any partial word is discarded.
  - `done_q` still updates during flush, so a `done` level that persists across the flush does not recapture.
  - A capture and a flush in the same cycle: the flush wins and the byte is discarded.
- `res` (asynchronous):
  - Outputs: `valid` = 0, `level` = 0, `ovf` = 0, `prng_ena` = 1, `dout` = 0 (storage cleared).
  - Internal state: `bidx` = 0, `done_q` = 0.
- Reset mid-word:
  - Any partial word is lost.
  - If `prng_done` is high when reset is released, it is captured once on the first edge after release. The PRNG is normally reset by the same `res`, which clears its `done`.

## Timing
- The PRNG raises `done` at edge t.
- Capture happens at edge t+1. If the byte completes a word, the push also happens at edge t+1.
- `valid` and `level` update combinationally after edge t+1: a word is visible one cycle after `done` is first seen high.
- A pop at edge p updates `level` and `dout` after edge p. Back-to-back pops are supported every cycle.
- `prng_ena` drops in the same cycle that `level` reaches DEPTH. It rises in the cycle after the pop that frees a slot.
- Steady state with `ready` held high: one word per 8*WORD_BYTES enabled PRNG cycles.

## Configuration
- Macro: `RAND_PACK_STATS_EN`.
- Defined:
  - Adds output port `word_cnt[15:0]`, counting delivered words (`valid && ready`).
  - Saturates at 16'hFFFF.
  - Cleared by `res` and `flush`.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, PRNG stub bytes 8'h11, 8'h22, 8'h33, 8'h44, each with a 1-cycle `done` pulse, `ready` = 0 -> `dout` = 32'h44332211, `valid` = 1 and `level` = 1 exactly one cycle after the 4th `done`.
- `prng_done` held high for 20 cycles after byte 8'hAA -> exactly one capture; `bidx` advances by 1.
- `ready` = 0, feed 4*DEPTH+4 bytes -> `level` = 4 and `prng_ena` = 0 once `level` = 4. Pop one word -> `prng_ena` = 1 in the next cycle and order is preserved (FIFO).
- Force a push while full with no pop (stub ignores `ena`) -> word dropped, `ovf` = 1 until `flush`, `level` stays 4.
- `flush` asserted after 2 of 4 bytes, then bytes 8'h01..8'h04 -> `dout` = 32'h04030201. No stale bytes.
- `RAND_PACK_STATS_EN` defined, 3 handshakes -> `word_cnt` = 3. Assert `res` mid-stream -> all outputs return to their reset values asynchronously, before the next `clk` edge.
